// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
//   Shared types and constants for the Pong VGA timing path.
//   - phase_t      : per-axis phase of the raster (SYNC, BP, ACTIVE, FP)
//   - axis_t       : selects the horizontal or vertical column of the table
//   - MODE_*       : video mode encodings carried on mode_sel
//   - TIMING_TABLE : sync/bp/active/fp lengths per mode and axis
//   - timing_len() : table lookup; the illegal mode falls back to mode 0
//   - next_phase() : SYNC -> BP -> ACTIVE -> FP -> SYNC
// -----------------------------------------------------------------------------
package vga_timing_pkg;

    typedef enum logic [1:0] {
        PH_SYNC   = 2'd0,
        PH_BP     = 2'd1,
        PH_ACTIVE = 2'd2,
        PH_FP     = 2'd3
    } phase_t;

    typedef enum logic {
        AXIS_H = 1'b0,
        AXIS_V = 1'b1
    } axis_t;

    localparam logic [1:0] MODE_640     = 2'd0;
    localparam logic [1:0] MODE_SIM     = 2'd1;
    localparam logic [1:0] MODE_320     = 2'd2;
    localparam logic [1:0] MODE_ILLEGAL = 2'd3;

    // Indexed [mode][axis][phase]; phase order matches phase_t.
    localparam int unsigned TIMING_TABLE [3][2][4] = '{
        '{'{96, 48, 640, 16}, '{2, 33, 480, 10}},   // mode 0: 640x480
        '{'{ 2,  3,   5,  2}, '{2,  3,   5,  2}},   // mode 1: simulation
        '{'{48, 24, 320,  8}, '{2, 16, 240,  5}}    // mode 2: 320x240
    };

    function automatic int unsigned timing_len(input logic [1:0] mode,
                                               input axis_t      axis,
                                               input phase_t     ph);
        logic [1:0] row;
        row = (mode == MODE_ILLEGAL) ? MODE_640 : mode;
        return TIMING_TABLE[row][axis][ph];
    endfunction

    function automatic phase_t next_phase(input phase_t ph);
        phase_t nxt;
        case (ph)
            PH_SYNC:   nxt = PH_BP;
            PH_BP:     nxt = PH_ACTIVE;
            PH_ACTIVE: nxt = PH_FP;
            default:   nxt = PH_SYNC;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/vga_timing_controller_phase_counter.sv
// -----------------------------------------------------------------------------
// phase_counter
//   One axis of the raster: walks SYNC -> BP -> ACTIVE -> FP, counting
//   0..len-1 inside each phase.
//   Ports:
//     clock, reset           : system clock, async active-low reset
//     advance                : step the counter by one unit (pixel or line)
//     restart                : force SYNC/0 (mode change at a frame boundary)
//     len_sync..len_fp       : lengths of the four phases
//     phase, count           : current phase and position within it
//     last                   : count is on the final unit of the current phase
//     wrap                   : last unit of FP, i.e. end of the whole axis period
// -----------------------------------------------------------------------------
module phase_counter
    import vga_timing_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             advance,
    input  logic             restart,
    input  logic [WIDTH-1:0] len_sync,
    input  logic [WIDTH-1:0] len_bp,
    input  logic [WIDTH-1:0] len_active,
    input  logic [WIDTH-1:0] len_fp,
    output phase_t           phase,
    output logic [WIDTH-1:0] count,
    output logic             last,
    output logic             wrap
);

    logic [WIDTH-1:0] cur_len;

    always_comb begin
        // NOTE: default first so every path assigns cur_len and no latch is inferred.
        cur_len = len_sync;
        case (phase)
            PH_SYNC:   cur_len = len_sync;
            PH_BP:     cur_len = len_bp;
            PH_ACTIVE: cur_len = len_active;
            PH_FP:     cur_len = len_fp;
            default:   cur_len = len_sync;
        endcase
    end

    assign last = (count == cur_len - WIDTH'(1));
    assign wrap = last && (phase == PH_FP);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase <= PH_SYNC;
            count <= '0;
        end else if (restart) begin
            phase <= PH_SYNC;
            count <= '0;
        end else if (advance) begin
            if (last) begin
                phase <= next_phase(phase);
                count <= '0;
            end else begin
                count <= count + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/vga_timing_controller.sv
// -----------------------------------------------------------------------------
// vga_timing_controller
//   Pixel-tick divider, horizontal/vertical phase machines and video-mode
//   owner for the Pong VGA path. Mode requests are queued and applied only at
//   a frame boundary so a raster is never torn.
//   Parameters:
//     DIVIDE    : system clocks per pixel tick (1..16)
//     WIDTH     : width of position and configuration buses
//     INIT_MODE : mode loaded at reset (0 for the real display)
//   Ports:
//     clock, reset               : system clock, async active-low reset
//     mode_sel, mode_req         : requested mode and request strobe
//     mode_ack, mode_err         : one-clock apply / reject pulses
//     pixel_tick                 : one-clock pulse every DIVIDE clocks
//     hsync, vsync               : active-low sync
//     line_end, frame_end        : last pixel of line / frame pulses
//     video_on                   : both axes in ACTIVE
//     xposition, yposition       : position inside the active area, else 0
//     v_synch_pulse..v_front_porch : vertical configuration of the current mode
// -----------------------------------------------------------------------------
module vga_timing_controller
    import vga_timing_pkg::*;
#(
    parameter int         DIVIDE    = 4,
    parameter int         WIDTH     = 10,
    parameter logic [1:0] INIT_MODE = MODE_640
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       mode_sel,
    input  logic             mode_req,
    output logic             mode_ack,
    output logic             mode_err,
    output logic             pixel_tick,
    output logic             hsync,
    output logic             vsync,
    output logic             line_end,
    output logic             frame_end,
    output logic             video_on,
    output logic [WIDTH-1:0] xposition,
    output logic [WIDTH-1:0] yposition,
    output logic [WIDTH-1:0] v_synch_pulse,
    output logic [WIDTH-1:0] v_back_porch,
    output logic [WIDTH-1:0] v_active_video,
    output logic [WIDTH-1:0] v_front_porch
);

    localparam int              DIV_W    = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVIDE - 1);

    logic [DIV_W-1:0] divider;
    logic [1:0]       cur_mode;
    logic [1:0]       pending_mode;
    logic             pending;
    logic             apply;
    logic             accept;

    logic [WIDTH-1:0] h_len_sync, h_len_bp, h_len_active, h_len_fp;
    phase_t           h_phase, v_phase;
    logic [WIDTH-1:0] h_count, v_count;
    logic             h_last, v_last, h_wrap, v_wrap;

    // ---------------------------------------------------------------- divider
    // The tick is registered, so it is low throughout reset and the first one
    // appears DIVIDE clocks after release for every legal DIVIDE, including 1.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            divider    <= '0;
            pixel_tick <= 1'b0;
        end else begin
            pixel_tick <= (divider == DIV_LAST);
            divider    <= (divider == DIV_LAST) ? '0 : divider + DIV_W'(1);
        end
    end

    // --------------------------------------------------------- phase machines
    always_comb begin
        h_len_sync   = WIDTH'(timing_len(cur_mode, AXIS_H, PH_SYNC));
        h_len_bp     = WIDTH'(timing_len(cur_mode, AXIS_H, PH_BP));
        h_len_active = WIDTH'(timing_len(cur_mode, AXIS_H, PH_ACTIVE));
        h_len_fp     = WIDTH'(timing_len(cur_mode, AXIS_H, PH_FP));
    end

    phase_counter #(.WIDTH(WIDTH)) u_h_counter (
        .clock      (clock),
        .reset      (reset),
        .advance    (pixel_tick),
        .restart    (apply),
        .len_sync   (h_len_sync),
        .len_bp     (h_len_bp),
        .len_active (h_len_active),
        .len_fp     (h_len_fp),
        .phase      (h_phase),
        .count      (h_count),
        .last       (h_last),
        .wrap       (h_wrap)
    );

    // The vertical mirror runs from the same configuration registers that
    // feed the external vertical unit, so the two cannot disagree.
    phase_counter #(.WIDTH(WIDTH)) u_v_counter (
        .clock      (clock),
        .reset      (reset),
        .advance    (line_end),
        .restart    (apply),
        .len_sync   (v_synch_pulse),
        .len_bp     (v_back_porch),
        .len_active (v_active_video),
        .len_fp     (v_front_porch),
        .phase      (v_phase),
        .count      (v_count),
        .last       (v_last),
        .wrap       (v_wrap)
    );

    // Per-phase end flags are not needed at this level; only the wraps are.
    logic unused_phase_last;
    assign unused_phase_last = h_last ^ v_last;

    // Decodes of flops only: these change exactly on the edge that consumes a tick.
    assign line_end  = pixel_tick && h_wrap;
    assign frame_end = line_end && v_wrap;
    assign hsync     = (h_phase != PH_SYNC);
    assign vsync     = (v_phase != PH_SYNC);
    assign video_on  = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
    assign xposition = (h_phase == PH_ACTIVE) ? h_count : '0;
    assign yposition = (v_phase == PH_ACTIVE) ? v_count : '0;

    // ------------------------------------------------------- mode sequencing
    // apply uses the pending flag from before this edge, so a request landing
    // on the frame_end clock is latched now and applied one frame later.
    assign apply  = frame_end && pending;
    assign accept = mode_req && !pending && (mode_sel != MODE_ILLEGAL);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur_mode       <= INIT_MODE;
            pending_mode   <= INIT_MODE;
            pending        <= 1'b0;
            mode_ack       <= 1'b0;
            mode_err       <= 1'b0;
            v_synch_pulse  <= WIDTH'(timing_len(INIT_MODE, AXIS_V, PH_SYNC));
            v_back_porch   <= WIDTH'(timing_len(INIT_MODE, AXIS_V, PH_BP));
            v_active_video <= WIDTH'(timing_len(INIT_MODE, AXIS_V, PH_ACTIVE));
            v_front_porch  <= WIDTH'(timing_len(INIT_MODE, AXIS_V, PH_FP));
        end else begin
            mode_ack <= apply;
            mode_err <= mode_req && !pending && (mode_sel == MODE_ILLEGAL);
            if (apply) begin
                cur_mode       <= pending_mode;
                pending        <= 1'b0;
                v_synch_pulse  <= WIDTH'(timing_len(pending_mode, AXIS_V, PH_SYNC));
                v_back_porch   <= WIDTH'(timing_len(pending_mode, AXIS_V, PH_BP));
                v_active_video <= WIDTH'(timing_len(pending_mode, AXIS_V, PH_ACTIVE));
                v_front_porch  <= WIDTH'(timing_len(pending_mode, AXIS_V, PH_FP));
            end else if (accept) begin
                pending      <= 1'b1;
                pending_mode <= mode_sel;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_controller.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_controller
//   Three instances share one clock:
//     dut_a : DIVIDE=1, reset mode 0 (640x480 raster timing)
//     dut_b : DIVIDE=1, reset mode 1 (short frames for mode-change sequences)
//     dut_c : DIVIDE=4, reset mode 1 (pixel stepping and line indexing)
//   Outputs are sampled on the falling edge; inputs change right after.
// -----------------------------------------------------------------------------
module tb_vga_timing_controller;

    localparam int W = 10;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp;
    int n_bad;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------- dut_a
    logic a_reset, a_req;
    logic [1:0] a_sel;
    logic a_ack, a_err, a_tick, a_hs, a_vs, a_le, a_fe, a_von;
    logic [W-1:0] a_x, a_y, a_vsp, a_vbp, a_vav, a_vfp;

    vga_timing_controller #(.DIVIDE(1), .WIDTH(W), .INIT_MODE(2'd0)) dut_a (
        .clock(clock), .reset(a_reset), .mode_sel(a_sel), .mode_req(a_req),
        .mode_ack(a_ack), .mode_err(a_err), .pixel_tick(a_tick),
        .hsync(a_hs), .vsync(a_vs), .line_end(a_le), .frame_end(a_fe),
        .video_on(a_von), .xposition(a_x), .yposition(a_y),
        .v_synch_pulse(a_vsp), .v_back_porch(a_vbp),
        .v_active_video(a_vav), .v_front_porch(a_vfp)
    );

    // ------------------------------------------------------------- dut_b
    logic b_reset, b_req;
    logic [1:0] b_sel;
    logic b_ack, b_err, b_tick, b_hs, b_vs, b_le, b_fe, b_von;
    logic [W-1:0] b_x, b_y, b_vsp, b_vbp, b_vav, b_vfp;

    vga_timing_controller #(.DIVIDE(1), .WIDTH(W), .INIT_MODE(2'd1)) dut_b (
        .clock(clock), .reset(b_reset), .mode_sel(b_sel), .mode_req(b_req),
        .mode_ack(b_ack), .mode_err(b_err), .pixel_tick(b_tick),
        .hsync(b_hs), .vsync(b_vs), .line_end(b_le), .frame_end(b_fe),
        .video_on(b_von), .xposition(b_x), .yposition(b_y),
        .v_synch_pulse(b_vsp), .v_back_porch(b_vbp),
        .v_active_video(b_vav), .v_front_porch(b_vfp)
    );

    // ------------------------------------------------------------- dut_c
    logic c_reset, c_req;
    logic [1:0] c_sel;
    logic c_ack, c_err, c_tick, c_hs, c_vs, c_le, c_fe, c_von;
    logic [W-1:0] c_x, c_y, c_vsp, c_vbp, c_vav, c_vfp;

    vga_timing_controller #(.DIVIDE(4), .WIDTH(W), .INIT_MODE(2'd1)) dut_c (
        .clock(clock), .reset(c_reset), .mode_sel(c_sel), .mode_req(c_req),
        .mode_ack(c_ack), .mode_err(c_err), .pixel_tick(c_tick),
        .hsync(c_hs), .vsync(c_vs), .line_end(c_le), .frame_end(c_fe),
        .video_on(c_von), .xposition(c_x), .yposition(c_y),
        .v_synch_pulse(c_vsp), .v_back_porch(c_vbp),
        .v_active_video(c_vav), .v_front_porch(c_vfp)
    );

    localparam logic [39:0] CFG_M0 = {10'd2, 10'd33, 10'd480, 10'd10};
    localparam logic [39:0] CFG_M1 = {10'd2, 10'd3,  10'd5,   10'd2};
    localparam logic [39:0] CFG_M2 = {10'd2, 10'd16, 10'd240, 10'd5};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before the end of the run");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        int lows;
        int lines;
        int errs;
        int acks;

        n_cmp   = 0;
        n_bad   = 0;
        a_reset = 1'b0; a_req = 1'b0; a_sel = 2'd0;
        b_reset = 1'b0; b_req = 1'b0; b_sel = 2'd0;
        c_reset = 1'b0; c_req = 1'b0; c_sel = 2'd0;

        // ---------------------------------------------------- reset state
        repeat (3) @(negedge clock);
        check("a_rst_flags", {a_hs, a_vs, a_tick, a_le, a_fe, a_von, a_ack, a_err}, 8'd0);
        check("a_rst_pos",   {a_x, a_y}, 20'd0);
        check("a_rst_cfg",   {a_vsp, a_vbp, a_vav, a_vfp}, CFG_M0);
        check("b_rst_flags", {b_hs, b_vs, b_tick, b_le, b_fe, b_von, b_ack, b_err}, 8'd0);
        check("b_rst_pos",   {b_x, b_y}, 20'd0);
        check("b_rst_cfg",   {b_vsp, b_vbp, b_vav, b_vfp}, CFG_M1);
        check("c_rst_flags", {c_hs, c_vs, c_tick, c_le, c_fe, c_von, c_ack, c_err}, 8'd0);
        check("c_rst_pos",   {c_x, c_y}, 20'd0);
        check("c_rst_cfg",   {c_vsp, c_vbp, c_vav, c_vfp}, CFG_M1);

        // ------------------------------------------- dut_a: mode 0 raster
        a_reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (i == 0) check("a_tick_every_clock", a_tick, 1'b1);
            if (a_hs) break;
            cnt++;
        end
        check("a_hsync_low_after_reset", cnt, 96);

        cnt = 0;
        while (!a_le && cnt < 2000) begin @(negedge clock); cnt++; end
        check("a_first_line_end", a_le, 1'b1);
        cnt = 0; lows = 0;
        do begin
            @(negedge clock);
            cnt++;
            if (!a_hs) lows++;
        end while (!a_le && cnt < 2000);
        check("a_line_period", cnt, 800);
        check("a_hsync_low_per_line", lows, 96);
        check("a_vsync_low_line1", a_vs, 1'b0);
        @(negedge clock);
        check("a_vsync_high_line2", a_vs, 1'b1);

        // ------------------------------------------- dut_b: mode 1 frame
        b_reset = 1'b1;
        cnt = 0;
        while (!b_fe && cnt < 400) begin @(negedge clock); cnt++; end
        check("b_first_frame_end", b_fe, 1'b1);
        cnt = 0; lines = 0;
        do begin
            @(negedge clock);
            cnt++;
            if (b_le) lines++;
        end while (!b_fe && cnt < 400);
        check("b_frame_period", cnt, 144);
        check("b_lines_per_frame", lines, 12);
        check("b_cfg_mode1", {b_vsp, b_vbp, b_vav, b_vfp}, CFG_M1);

        // ------------------------------------------- dut_b: illegal mode
        @(negedge clock);
        b_sel = 2'd3; b_req = 1'b1;
        errs = 0; acks = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (i == 0) check("b_err_next_clock", b_err, 1'b1);
            if (i == 0) b_req = 1'b0;
            errs += int'(b_err);
            acks += int'(b_ack);
        end
        check("b_err_pulse_count", errs, 1);
        check("b_err_no_ack", acks, 0);
        check("b_err_cfg_kept", {b_vsp, b_vbp, b_vav, b_vfp}, CFG_M1);

        // ----------------------- dut_b: two requests, only the first applies
        cnt = 0;
        while (!b_fe && cnt < 200) begin @(negedge clock); cnt++; end
        repeat (20) @(negedge clock);
        b_sel = 2'd2; b_req = 1'b1;
        @(negedge clock); b_req = 1'b0;
        repeat (3) @(negedge clock);
        b_sel = 2'd0; b_req = 1'b1;
        @(negedge clock); b_req = 1'b0;
        cnt = 0; acks = 0;
        while (!b_fe && cnt < 200) begin
            @(negedge clock);
            cnt++;
            acks += int'(b_ack);
        end
        check("b_apply_frame_end", b_fe, 1'b1);
        check("b_no_ack_before_frame_end", acks, 0);
        check("b_cfg_held_until_apply", {b_vsp, b_vbp, b_vav, b_vfp}, CFG_M1);
        @(negedge clock);
        check("b_ack_after_apply", b_ack, 1'b1);
        check("b_cfg_mode2", {b_vsp, b_vbp, b_vav, b_vfp}, CFG_M2);
        check("b_restart_sync", {b_hs, b_vs, b_x}, 12'd0);
        cnt = 0;
        while (!b_hs && cnt < 200) begin cnt++; @(negedge clock); end
        check("b_mode2_hsync_low", cnt, 48);
        cnt = 0;
        while (!b_le && cnt < 500) begin @(negedge clock); cnt++; end
        cnt = 0;
        do begin @(negedge clock); cnt++; end while (!b_le && cnt < 1000);
        check("b_mode2_line_period", cnt, 400);

        // ----------------------------------- dut_b: reset during a request
        b_sel = 2'd1; b_req = 1'b1;
        @(negedge clock); b_req = 1'b0;
        repeat (5) @(negedge clock);
        #2 b_reset = 1'b0;
        #1;
        check("b_async_rst_flags", {b_hs, b_vs, b_tick, b_le, b_fe, b_von, b_ack, b_err}, 8'd0);
        check("b_async_rst_pos", {b_x, b_y}, 20'd0);
        check("b_async_rst_cfg", {b_vsp, b_vbp, b_vav, b_vfp}, CFG_M1);
        @(negedge clock);
        b_reset = 1'b1;
        acks = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            acks += int'(b_ack);
        end
        check("b_no_ack_after_reset", acks, 0);
        check("b_cfg_after_reset", {b_vsp, b_vbp, b_vav, b_vfp}, CFG_M1);

        // ------------------------- dut_b: request coincident with frame_end
        cnt = 0;
        while (!b_fe && cnt < 200) begin @(negedge clock); cnt++; end
        check("b_coincident_frame_end", b_fe, 1'b1);
        b_sel = 2'd2; b_req = 1'b1;
        cnt = 0;
        do begin
            @(negedge clock);
            cnt++;
            if (cnt == 1) b_req = 1'b0;
        end while (!b_ack && cnt < 400);
        check("b_coincident_ack_latency", cnt, 145);
        check("b_coincident_cfg", {b_vsp, b_vbp, b_vav, b_vfp}, CFG_M2);

        // ------------------------------------ dut_c: DIVIDE=4, pixel steps
        c_reset = 1'b1;
        cnt = 0;
        do begin @(negedge clock); cnt++; end while (!c_tick && cnt < 20);
        check("c_first_tick", cnt, 4);
        for (int l = 0; l < 6; l++) begin
            cnt = 0;
            while (!c_von && cnt < 600) begin @(negedge clock); cnt++; end
            check("c_line_y", {c_von, c_y}, {1'b1, W'(l % 5)});
            for (int i = 0; i < 20; i++) begin
                check("c_x_step", {c_von, c_x}, {1'b1, W'(i / 4)});
                @(negedge clock);
            end
            check("c_video_off", c_von, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
